mips_wb_writer: RTL
===================

// Module: mips_wb_writer
// PURPOSE
//  Write-side master for the 2R/1W register file. It merges two result sources
//  into the single regfile write port (wen/waddr/wdata). Source 1 is the in-order
//  pipeline writeback, which has no backpressure. Source 2 is the multi-cycle
//  mul/div unit, which hands off over valid/ready into a small FIFO. The block also
//  publishes a pending-write scoreboard so decode can stall on in-flight results.
// PARAMETERS
//  DEPTH        2   long-latency FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 8   cycles a FIFO head may wait before pipe_hold asserts
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  wb_valid   in   1   pipeline writeback valid this cycle
//  wb_wen     in   4   pipeline byte-lane enables (any bit set = write)
//  wb_waddr   in   5   pipeline destination register
//  wb_wdata   in   32  pipeline result (full word, lanes pre-merged)
//  ll_valid   in   1   mul/div result offered
//  ll_ready   out  1   FIFO can accept (= !full)
//  ll_waddr   in   5   mul/div destination register
//  ll_wdata   in   32  mul/div result
//  wen        out  4   to regfile write enable
//  waddr      out  5   to regfile write address
//  wdata      out  32  to regfile write data
//  pend_mask  out  32  bit r set = write to r still in flight
//  pipe_hold  out  1   request one pipeline bubble so the FIFO can drain
// BEHAVIOUR
//  - Reset (async): wen=0, waddr=0, wdata=0, FIFO empty, age=0, pend_mask=0,
//    pipe_hold=0, ll_ready=1. Reset mid-operation discards all queued results.
//  - wen/waddr/wdata are registered. A selected source appears 1 cycle after
//    selection; the regfile commits it on the following edge.
//  - Per-cycle selection:
//    - P: wb_valid && |wb_wen && wb_waddr!=0 -> drive wb_* next cycle.
//    - Else if the FIFO is non-empty, pop the head. If the head is live, drive
//      wen=4'hF, its waddr and its wdata. If the head is killed, drive wen=0.
//    - Else drive wen=0; waddr/wdata hold their previous values.
//  - A pipeline write to $0, or with wen=0, is dropped and counts as idle.
//  - LL handshake: transfer when ll_valid && ll_ready. ll_ready depends only on
//    full; a same-cycle pop does not raise it (no fall-through).
//  - An accepted ll result with ll_waddr==0 completes the handshake but is not
//    enqueued.
//  - FIFO: circular, DEPTH entries, each {live, waddr, wdata}.
//    - Pointers have log2(DEPTH)+1 bits; the wrap bit distinguishes full from empty.
//    - Push and pop in the same cycle are both legal.
//  - WAW kill: when P fires for register X, every queued live entry with
//    waddr==X is cleared to !live, because the newer pipeline value wins.
//    - An entry pushed in the same cycle with waddr==X is NOT killed; it is newer.
//  - pend_mask: OR of one-hot(waddr) over all live FIFO entries, plus one-hot(waddr)
//    of the output register when |wen. Bit 0 is always 0. The mask is
//    combinational from state.
//  - Age counter:
//    - Resets to 0 on every pop and whenever the FIFO is empty.
//    - Increments each cycle the FIFO is non-empty and no pop occurs.
//    - Saturates at STARVE_LIMIT.
//  - pipe_hold = (age == STARVE_LIMIT). Decode responds by inserting a bubble, which
//    makes P idle so the head drains. pipe_hold is registered and deasserts the
//    cycle after that pop.
//  - Throughput: one regfile write per cycle, max. The pipeline always wins.
// TESTING
//  1. Reset: assert rst mid-stream with 2 FIFO entries queued. Required: all outputs
//     0 and ll_ready=1 immediately. After release, no stale write appears.
//  2. Pipeline only: wb_valid=1, wen=F, waddr=5, data=0x1234 -> next cycle wen=F,
//     waddr=5, wdata=0x1234, pend_mask=0x20. A wb write to $0 gives wen=0.
//  3. Contention: ll push waddr=7, data=0xAA while wb writes r3 for 3 cycles.
//     Required: r3 on the port each cycle; r7 emitted in the first idle cycle with
//     wen=F; pend_mask bit7 set until then.
//  4. Full FIFO: push DEPTH entries with wb busy. Required: ll_ready=0. Holding
//     ll_valid=1 accepts no extra entry. One pop raises ll_ready the next cycle.
//  5. WAW kill: queue r9=0x11, then wb writes r9=0x22. Required: the port emits
//     r9=0x22; the later pop of the killed entry gives wen=0; the final r9 is 0x22.
//  6. Starvation: wb busy continuously with 1 FIFO entry. Required: pipe_hold=1
//     after STARVE_LIMIT=8 cycles. Drop wb_valid for 1 cycle: the entry drains and
//     pipe_hold falls the next cycle.

Source files
------------

// File: rtl/mips_wb_writer.sv
// Register-file write master: merges in-order writeback with a small mul/div result FIFO,
// kills stale queued results on WAW, and publishes a pending-write scoreboard.
module mips_wb_writer #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [3:0]  wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_waddr,
    input  logic [31:0] ll_wdata,
    output logic [3:0]  wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [31:0] pend_mask,
    output logic        pipe_hold
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(STARVE_LIMIT + 1);
    localparam logic [GW-1:0] AGE_MAX = GW'(STARVE_LIMIT);

    logic [DEPTH-1:0] live;
    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [GW-1:0]    age;
    logic [GW-1:0]    age_next;

    logic full;
    logic empty;
    logic p_fire;
    logic push;
    logic pop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign ll_ready = !full;

    assign p_fire = wb_valid && (|wb_wen) && (wb_waddr != 5'd0);
    assign pop    = !p_fire && !empty;
    // $0 results complete the handshake but are never queued
    assign push   = ll_valid && ll_ready && (ll_waddr != 5'd0);

    always_comb begin
        age_next = age;
        if (empty || pop)
            age_next = '0;
        else if (age != AGE_MAX)
            age_next = age + 1'b1;
    end

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i])
                pend_mask = pend_mask | (32'd1 << q_addr[i]);
        if (|wen)
            pend_mask = pend_mask | (32'd1 << waddr);
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen       <= 4'd0;
            waddr     <= 5'd0;
            wdata     <= 32'd0;
            live      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            age       <= '0;
            pipe_hold <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= 5'd0;
                q_data[i] <= 32'd0;
            end
        end else begin
            age       <= age_next;
            pipe_hold <= (age_next == AGE_MAX);

            if (p_fire) begin
                wen   <= wb_wen;
                waddr <= wb_waddr;
                wdata <= wb_wdata;
                // newer pipeline value supersedes queued results; a same-cycle push lands
                // in a free slot below and is therefore never killed
                for (int i = 0; i < DEPTH; i++)
                    if (live[i] && q_addr[i] == wb_waddr)
                        live[i] <= 1'b0;
            end else if (pop) begin
                live[rd_idx] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
                if (live[rd_idx]) begin
                    wen   <= 4'hF;
                    waddr <= q_addr[rd_idx];
                    wdata <= q_data[rd_idx];
                end else begin
                    wen <= 4'd0;
                end
            end else begin
                wen <= 4'd0;
            end

            if (push) begin
                live[wr_idx]   <= 1'b1;
                q_addr[wr_idx] <= ll_waddr;
                q_data[wr_idx] <= ll_wdata;
                wr_ptr         <= wr_ptr + 1'b1;
            end
        end
    end
endmodule
